// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    // Indexed by {row, col}; * and # are reported as E and F.
    localparam logic [3:0] KEYMAP [NUM_ROWS*NUM_COLS] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic is_onehot(input logic [NUM_COLS-1:0] v);
        return $countones(v) == 1;
    endfunction
endpackage

// File: rtl/keypad_keymap.sv
// Maps a row index and a one-hot column to the key code.
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [1:0]          row_idx,
    input  logic [NUM_COLS-1:0] col_hot,
    output logic [3:0]          code
);
    logic [1:0] col_idx;

    always_comb begin
        col_idx = '0;
        for (int i = 0; i < NUM_COLS; i++)
            if (col_hot[i]) col_idx = 2'(i);
    end

    assign code = KEYMAP[{row_idx, col_idx}];
endmodule

// File: rtl/keypad_scanner.sv
// Row scanner with press/release debounce for a 4x4 keypad; one valid pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] col,
    output logic [NUM_ROWS-1:0] row,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);
    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_t              state;
    logic [1:0]          row_idx;
    logic [DW-1:0]       dwell;
    logic [CW-1:0]       cnt;
    logic [NUM_COLS-1:0] cap_col;
    logic [3:0]          map_code;

    // row_idx doubles as the captured row: it is frozen outside SCAN.
    keypad_keymap u_keymap (
        .row_idx (row_idx),
        .col_hot (cap_col),
        .code    (map_code)
    );

    assign row = NUM_ROWS'(1) << row_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= '0;
            dwell     <= '0;
            cnt       <= '0;
            cap_col   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (is_onehot(col)) begin
                            cap_col <= col;
                            cnt     <= '0;
                            state   <= DEB_PRESS;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                DEB_PRESS: begin
                    if (col == cap_col) begin
                        if (cnt == DEB_LAST) begin
                            key_valid <= 1'b1;
                            key_code  <= map_code;
                            key_held  <= 1'b1;
                            state     <= HELD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        row_idx <= row_idx + 2'd1;
                        dwell   <= '0;
                        state   <= SCAN;
                    end
                end
                HELD: begin
                    // Extra keys are tolerated; only a fully idle column starts release.
                    if (col == '0) begin
                        cnt   <= '0;
                        state <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (col != '0) begin
                        state <= HELD;
                    end else if (cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        row_idx  <= row_idx + 2'd1;
                        dwell    <= '0;
                        state    <= SCAN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad emulator plus a behavioural reference model.
module tb_keypad_scanner;
    localparam int SC = 4;
    localparam int DB = 8;
    localparam logic [3:0] MAP [16] = '{1, 2, 3, 'hA, 4, 5, 6, 'hB, 7, 8, 9, 'hC, 'hE, 0, 'hF, 'hD};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col = '0;
    logic [3:0] row, key_code;
    logic       key_valid, key_held;

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    logic [15:0] keys = '0;   // bit r*4+c = key (r,c) pressed

    // Reference model: scan position counted in cycles, debounce as run lengths.
    int   m_tick, m_row, m_run;
    bit   m_locked, m_acc, m_rel, m_valid, m_held;
    logic [3:0] m_hot, m_code;

    always @(posedge clk) begin
        if (!reset) begin
            m_tick = 0; m_row = 0; m_run = 0; m_locked = 0; m_acc = 0; m_rel = 0;
            m_valid = 0; m_held = 0; m_hot = 0; m_code = 0;
        end else begin
            m_valid = 0;
            if (!m_locked) begin
                if (m_tick == SC - 1) begin
                    m_tick = 0;
                    if ($countones(col) == 1) begin m_hot = col; m_run = 0; m_locked = 1; end
                    else m_row = (m_row + 1) % 4;
                end else m_tick++;
            end else if (!m_acc) begin
                if (col == m_hot) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_valid = 1; m_held = 1; m_acc = 1;
                        m_code = MAP[m_row * 4 + $clog2(m_hot)];
                    end
                end else begin
                    m_locked = 0; m_row = (m_row + 1) % 4; m_tick = 0;
                end
            end else if (!m_rel) begin
                if (col == 0) begin m_rel = 1; m_run = 0; end
            end else if (col != 0) begin
                m_rel = 0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    m_held = 0; m_acc = 0; m_locked = 0; m_rel = 0;
                    m_row = (m_row + 1) % 4; m_tick = 0;
                end
            end
        end
    end

    logic [9:0] dut_v, exp_v;
    assign dut_v = {row, key_code, key_valid, key_held};
    assign exp_v = {4'b0001 << m_row, m_code, m_valid, m_held};

    // Observe at negedge, then present the column lines for the currently driven row.
    task automatic tick();
        logic [3:0] c;
        @(negedge clk);
        cyc++;
        c = '0;
        for (int i = 0; i < 4; i++) if (row[i]) c |= keys[i*4 +: 4];
        col = c;
    endtask

    task automatic test_reset();
        reset = 1'b0; keys = '0;
        repeat (3) begin
            tick();
            checks++;
            if (dut_v !== 10'b0001_0000_0_0) begin
                errors++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, dut_v, 10'b0001_0000_0_0);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_idle();
        logic [3:0] want;
        for (int i = 1; i <= 32; i++) begin
            tick();
            want = 4'b0001 << ((i / SC) % 4);
            checks++;
            if (row !== want || key_valid !== 1'b0 || key_code !== 4'h0) begin
                errors++; $display("FAIL idle_scan cyc=%0d row=%b want=%b valid=%b code=%h", cyc, row, want, key_valid, key_code);
            end
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL idle_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
        end
    endtask

    task automatic test_press();
        int pulses = 0, n = 0;
        keys = 16'h0040;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL press_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
            if (key_valid) begin
                pulses++;
                checks++;
                if (key_code !== 4'h6) begin errors++; $display("FAIL press_code got=%h want=6", key_code); end
            end
        end
        checks++;
        if (pulses != 1 || row !== 4'b0010 || key_held !== 1'b1) begin
            errors++; $display("FAIL press_once pulses=%0d row=%b held=%b want 1/0010/1", pulses, row, key_held);
        end
        keys = '0; tick();
        while (key_held && n < 30) begin
            tick(); n++;
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL press_rel_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
        end
        checks++;
        if (n != DB + 1) begin errors++; $display("FAIL press_release_latency got=%0d want=%0d", n, DB + 1); end
    endtask

    task automatic test_bounce();
        int pulses = 0, n = 0;
        for (int i = 0; i < 30; i++) begin
            keys = ((i / 3) % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            if (key_valid) pulses++;
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL bounce_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL bounce_quiet pulses=%0d want=0", pulses); end
        keys = 16'h0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (key_valid) begin
                pulses++;
                checks++;
                if (key_code !== 4'h1) begin errors++; $display("FAIL bounce_code got=%h want=1", key_code); end
            end
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL bounce_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL bounce_once pulses=%0d want=1", pulses); end
        keys = '0; tick();
        while (key_held && n < 30) begin tick(); n++; end
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_release held=%b want=0", key_held); end
    endtask

    task automatic test_ambiguous();
        int pulses = 0;
        bit seen_r3 = 0, wrapped = 0;
        keys = 16'h5000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (key_valid) pulses++;
            if (row == 4'b1000) seen_r3 = 1;
            if (seen_r3 && row == 4'b0001) wrapped = 1;
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL ambig_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
        end
        checks++;
        if (pulses != 0 || !wrapped) begin errors++; $display("FAIL ambig_scan pulses=%0d wrapped=%0d want 0/1", pulses, wrapped); end
        keys = '0;
    endtask

    task automatic test_ignore_other();
        int pulses = 0, n = 0;
        keys = 16'h2000;
        for (int i = 0; i < 40 && pulses == 0; i++) begin
            tick();
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses != 1 || key_code !== 4'h0) begin errors++; $display("FAIL ignore_accept pulses=%0d code=%h want 1/0", pulses, key_code); end
        keys = 16'h2800;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_valid) pulses++;
            checks++;
            if (row !== 4'b1000 || key_held !== 1'b1) begin errors++; $display("FAIL ignore_frozen row=%b held=%b want 1000/1", row, key_held); end
        end
        keys = '0; tick();
        while (key_held && n < 30) begin tick(); n++; end
        checks++;
        if (pulses != 1 || row !== 4'b0001 || key_held !== 1'b0) begin
            errors++; $display("FAIL ignore_resume pulses=%0d row=%b held=%b want 1/0001/0", pulses, row, key_held);
        end
    endtask

    task automatic test_release_bounce();
        int pulses = 0, n = 0;
        keys = 16'h8000;
        for (int i = 0; i < 40 && pulses == 0; i++) begin
            tick();
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses != 1 || key_code !== 4'hD) begin errors++; $display("FAIL relb_accept pulses=%0d code=%h want 1/D", pulses, key_code); end
        for (int i = 0; i < 10; i++) begin
            keys = (i < 4) ? 16'h0000 : 16'h8000;
            tick();
            if (key_valid) pulses++;
            checks++;
            if (key_held !== 1'b1 || dut_v !== exp_v) begin
                errors++; $display("FAIL relb_glitch cyc=%0d held=%b dut=%h model=%h", cyc, key_held, dut_v, exp_v);
            end
        end
        keys = '0; tick();
        while (key_held && n < 30) begin
            tick(); n++;
            if (key_valid) pulses++;
        end
        checks++;
        if (n != DB + 1 || pulses != 1) begin errors++; $display("FAIL relb_latency got=%0d pulses=%0d want %0d/1", n, pulses, DB + 1); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0, n = 0;
        keys = 16'h0400;
        while (!(m_locked && !m_acc && m_row == 2) && n < 40) begin tick(); n++; end
        checks++;
        if (n >= 40) begin errors++; $display("FAIL rstmid_capture timeout=%0d want <40", n); end
        repeat (3) begin tick(); if (key_valid) pulses++; end
        reset = 1'b0; tick();
        tick();
        checks++;
        if (row !== 4'b0001 || key_held !== 1'b0 || key_code !== 4'h0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_state row=%b held=%b code=%h valid=%b want 0001/0/0/0", row, key_held, key_code, key_valid);
        end
        repeat (10) begin tick(); if (key_valid) pulses++; end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rstmid_nopulse pulses=%0d want=0", pulses); end
        keys = '0; reset = 1'b1; tick();
    endtask

    task automatic test_random();
        int dut_p = 0, mod_p = 0, r, c, len;
        for (int it = 0; it < 12; it++) begin
            r = $urandom_range(0, 3); c = $urandom_range(0, 3);
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                keys = $urandom_range(0, 1) ? (16'h1 << (r * 4 + c)) : 16'h0;
                tick();
                if (key_valid) dut_p++;
                if (m_valid) mod_p++;
                checks++;
                if (dut_v !== exp_v) begin errors++; $display("FAIL rand_bounce cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
            end
            keys = 16'h1 << (r * 4 + c);
            if ($urandom_range(0, 3) == 0) keys |= 16'h1 << (r * 4 + ((c + 1) % 4));
            len = $urandom_range(20, 40);
            for (int i = 0; i < len + 25; i++) begin
                if (i == len) keys = '0;
                tick();
                if (key_valid) dut_p++;
                if (m_valid) mod_p++;
                checks++;
                if (dut_v !== exp_v) begin errors++; $display("FAIL rand_model cyc=%0d dut=%h model=%h", cyc, dut_v, exp_v); end
            end
        end
        checks++;
        if (dut_p != mod_p) begin errors++; $display("FAIL rand_pulses got=%0d want=%0d", dut_p, mod_p); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_ambiguous();
        test_ignore_other();
        test_release_bounce();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4 rows of the 4x4 matrix keypad one-hot and reads the 4 column lines after the 2-flop column synchronizer.
- Detects a single pressed key, debounces its press and its release, and emits one registered key code plus a one-cycle valid pulse per press.
- Sits between the column synchronizer and the digit-storage/display logic.
- Electrical convention: rows driven active-high; columns pulled down, so a pressed key reads 1 and idle reads 0000.

Parameters:
- SCAN_CYCLES, 16, clk cycles each row is driven during scanning; must be >= 3 to cover synchronizer latency.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles needed to accept a press and to accept a release.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- col  input  4  synchronized column lines, bit i = column i, 1 = pressed
- row  output  4  one-hot row drive, bit i = row i
- key_code  output  4  code of the last accepted key; held until the next accept
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_held  output  1  high from accept until release debounce completes

Behaviour:
- Reset (reset==0 at posedge clk): state SCAN, row=0001, dwell and debounce counters 0, key_code=0, key_valid=0, key_held=0. Reset mid-operation aborts everything; no key_valid is issued.
- Key map (row,col -> code), row0: 1,2,3,A; row1: 4,5,6,B; row2: 7,8,9,C; row3: E(*),0,F(#),D.
- SCAN:
  - row is held for SCAN_CYCLES cycles, then rotates 0001->0010->0100->1000->0001.
  - col is sampled only on the last dwell cycle.
  - If exactly one col bit is set: capture row index and col one-hot, freeze row, clear the debounce counter, go to DEB_PRESS.
  - If col is 0000 or has more than one bit set (ambiguous): continue scanning.
- DEB_PRESS:
  - Each cycle with col == captured one-hot, increment the counter.
  - Any mismatch: return to SCAN at the next row with the dwell counter cleared.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match: next cycle key_valid=1 for exactly one cycle, key_code updated, key_held=1, go to HELD.
- HELD:
  - row stays frozen; other keys, on any row, are ignored.
  - Stay while the captured col bit is 1, even if extra bits appear.
  - When col == 0000: clear the counter and go to DEB_REL.
- DEB_REL:
  - Count consecutive col==0000 cycles.
  - Any nonzero col: return to HELD; no new key_valid.
  - When the counter reaches DEBOUNCE_CYCLES-1: key_held=0, go to SCAN, resume at the row after the held row.
- Latency:
  - Let T be the sample cycle with a single bit set, with col stable from then on.
  - key_valid asserts at T+DEBOUNCE_CYCLES+1.
  - key_held falls DEBOUNCE_CYCLES+1 cycles after col first reads 0000.
- Counters saturate and never wrap. Widths: $clog2 of each parameter, minimum 1.
- At most one key_valid per physical press; holding a key never auto-repeats.

Decomposition:
- Package keypad_pkg holds:
  - NUM_ROWS=4 and NUM_COLS=4
  - state enum {SCAN, DEB_PRESS, HELD, DEB_REL}
  - the 16-entry key-map constant
- Sub-module keypad_keymap: combinational 2-bit row index + 4-bit col one-hot -> 4-bit code, using the package constant.

Test Plan (bench uses SCAN_CYCLES=4, DEBOUNCE_CYCLES=8):
- Reset, then no press: row cycles 0001,0010,0100,1000 every 4 cycles; key_valid never asserts; key_code=0.
- Press row1/col2 (col=0100 whenever row==0010), held 40 cycles -> row freezes at 0010; single key_valid pulse at T+9 with key_code=6; key_held=1 until 9 cycles after release.
- Bounce: col=0001 on row0 toggles every 3 cycles for 30 cycles, then stable -> no pulse during bouncing; exactly one pulse with key_code=1 after 8 stable cycles.
- Two keys on the same row (row3, col=0101) -> no capture, scan continues. Press row2/col3 while row3/col1 is held -> ignored; after row3 release, scanning resumes at row0.
- Release bounce: after accepting D (row3/col3), col drops to 0000 for 4 cycles, returns to 1000, then stays 0000 -> key_held stays 1 through the glitch; no second key_valid; key_held falls 9 cycles after the final 0000.
- Assert reset during DEB_PRESS of key 9 (row2/col2) -> next cycle row=0001, key_held=0, key_code=0; no key_valid.
